inv_sub_shift_stage: RTL and testbench
======================================

INV_SUB_SHIFT_STAGE -- requirements
Module: inv_sub_shift_stage

Interface
REQ-001 The block SHALL provide parameter LANES, default 4, giving bytes substituted per cycle; legal values 1, 2, 4, 8, 16; N = 16/LANES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  state_in carries a valid 128-bit AES state.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 state_in  input  128  input state; byte k = state_in[127-8k -: 8], column-major (row = k mod 4, col = k div 4).
REQ-007 out_valid  output  1  state_out holds a completed result.
REQ-008 out_ready  input  1  downstream consumes state_out this cycle.
REQ-009 state_out  output  128  InvSubBytes(InvShiftRows(state_in)), same byte ordering as state_in.
REQ-010 busy  output  1  high while in BUSY state.

Function
REQ-011 The block SHALL compute out[r][c] = InvSbox(in[r][(c - r) mod 4]) for r, c in 0..3.
REQ-012 The block SHALL use exactly LANES instances of the existing InverseSbox module, time-multiplexed; no other substitution table.
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 In IDLE: in_ready = 1; in_valid = 1 at an edge captures state_in into an internal 128-bit register, clears the lane counter, and enters BUSY.
REQ-015 In BUSY: each edge writes LANES result bytes, output indices counter*LANES to counter*LANES+LANES-1 ascending, into the result register, then increments the counter.
REQ-016 On the edge that writes the final group (counter = N-1): the FSM SHALL enter DONE and out_valid SHALL be 1 from that edge.
REQ-017 Latency SHALL be exactly N edges from the accepting edge to out_valid rising (4 for LANES = 4, 1 for LANES = 16).
REQ-018 In DONE: out_valid = 1 and state_out stable until an edge with out_ready = 1; that edge returns the FSM to IDLE.
REQ-019 in_ready SHALL be 0 in BUSY and DONE; in_valid is ignored there and the captured state does not change.
REQ-020 out_valid SHALL be 0 in IDLE and BUSY; out_ready is ignored there.
REQ-021 state_out SHALL expose the result register at all times; its value outside DONE has no meaning.
REQ-022 Throughput SHALL be one state per N+2 cycles with continuous handshakes: the DONE-to-IDLE edge does not accept a new input.
REQ-023 busy SHALL equal (state == BUSY).
REQ-024 The lane counter SHALL be ceil(log2(N)) bits, minimum 1, and SHALL wrap to 0 only through re-entry to BUSY.

Reset
REQ-025 rst = 1 at an edge SHALL force IDLE, in_ready = 1 (after the edge), out_valid = 0, busy = 0, counter = 0, and input and result registers = 0.
REQ-026 rst SHALL take priority over every handshake in the same cycle; a reset during BUSY or DONE discards the state in flight with no output produced.
REQ-027 in_valid = 1 during a rst = 1 cycle SHALL NOT be accepted.

Verification
REQ-028 All-zero state accepted, out_ready = 1 held -> out_valid rises 4 edges later with state_out = 0x52 in all 16 bytes, for one cycle.
REQ-029 state_in = 0x63 in all 16 bytes -> state_out = 0, 128 bits.
REQ-030 FIPS-197 AES-256 inverse round 1: state_in = aa5ece06ee6e3c56dde68bac2621bebf -> state_out = 627bceb9999d5aaac945ecf423f56da5.
REQ-031 Backpressure: out_ready = 0 for 10 cycles in DONE with in_valid toggling -> state_out stable, in_ready = 0, out_valid = 1; the first out_ready = 1 edge returns to IDLE with out_valid = 0.
REQ-032 rst pulsed on the 2nd BUSY edge -> no out_valid is produced; the next accepted all-zero state returns all-0x52 with normal latency.
REQ-033 Repeat scenarios REQ-028 to REQ-030 with LANES = 1 (latency 16) and LANES = 16 (latency 1) -> identical results; random back-to-back traffic is checked against a software model.

Source files
------------

// File: rtl/inv_sub_shift_stage.sv
// ---------------------------------------------------------------------------
// inv_sub_shift_stage
//
// Purpose: one AES decryption half-round, InvSubBytes(InvShiftRows(state)).
// The input state is captured once, then LANES bytes per cycle are pushed
// through LANES shared InverseSbox instances until all 16 result bytes are
// written. The finished result is held until downstream takes it.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   state_in carries a valid 128-bit state
//   in_ready   block can accept a state this cycle (IDLE only)
//   state_in   input state, byte k = state_in[127-8k -: 8], column-major
//   out_valid  state_out holds a completed result (DONE only)
//   out_ready  downstream consumes state_out this cycle
//   state_out  result register, same byte ordering as state_in
//   busy       high while substitution is in progress
//
// Also contains InverseSbox, the byte-wide AES inverse substitution table.
// ---------------------------------------------------------------------------

// InverseSbox: combinational AES inverse S-box lookup.
//   sub_i  byte to substitute
//   sub_o  InvSbox(sub_i)
module InverseSbox (
    input  logic [7:0] sub_i,
    output logic [7:0] sub_o
);

    // Entry x sits at bits [2047-8x -: 8]; for an 11-bit index,
    // 2047 - 8x is the bitwise complement of {x, 3'b000}.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Look up the byte for sub_i in the packed table.
    assign sub_o = INV_SBOX[~{sub_i, 3'b000} -: 8];

endmodule

module inv_sub_shift_stage #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsmState_t;

    fsmState_t     fsm_q, fsm_d;
    logic [CW-1:0] count_q, count_d;
    logic [127:0]  inReg_q, inReg_d;
    logic [127:0]  resultReg_q, resultReg_d;

    logic [7:0] sboxIn  [LANES];
    logic [7:0] sboxOut [LANES];

    // Output byte k lives at row k%4, column k/4. InvShiftRows moves row r
    // right by r, so it is fed from the input byte in the same row at
    // column (col - row) mod 4.
    function automatic int srcIdx(input int k);
        int row;
        int col;
        row = k % 4;
        col = k / 4;
        return row + 4 * ((col - row + 4) % 4);
    endfunction

    // Steer the input bytes needed by the current output group onto the
    // shared S-box lanes; lane j handles output byte count*LANES + j.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            sboxIn[j] = inReg_q[127 - 8 * srcIdx(int'(count_q) * LANES + j) -: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : gLane
        InverseSbox uSbox (
            .sub_i (sboxIn[g]),
            .sub_o (sboxOut[g])
        );
    end

    // Next-state and handshake logic. The counter is not advanced on the
    // final group so it only returns to zero when a new state is accepted.
    always_comb begin
        fsm_d       = fsm_q;
        count_d     = count_q;
        inReg_d     = inReg_q;
        resultReg_d = resultReg_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    inReg_d = state_in;
                    count_d = '0;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < LANES; j++) begin
                    resultReg_d[127 - 8 * (int'(count_q) * LANES + j) -: 8] = sboxOut[j];
                end
                if (count_q == LAST) begin
                    fsm_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            count_q     <= '0;
            inReg_q     <= '0;
            resultReg_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            count_q     <= count_d;
            inReg_q     <= inReg_d;
            resultReg_q <= resultReg_d;
        end
    end

    assign state_out = resultReg_q;
    assign busy      = (fsm_q == BUSY);

endmodule

// File: tb/tb_inv_sub_shift_stage.sv
// ---------------------------------------------------------------------------
// tb_inv_sub_shift_stage
//
// Three instances of inv_sub_shift_stage (LANES = 1, 4, 16) share one clock
// and reset. Results are compared with an arithmetic AES model: the inverse
// S-box is derived from the inverse affine map and GF(2^8) inversion.
// ---------------------------------------------------------------------------
module tb_inv_sub_shift_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid   [3];
    logic         outReady  [3];
    logic [127:0] stateIn   [3];
    logic         inReady   [3];
    logic         outValid  [3];
    logic         busy      [3];
    logic [127:0] stateOut  [3];

    int latencyOf [3] = '{16, 4, 1};

    int assertCount = 0;
    int failCount   = 0;

    logic [127:0] pendingState [3];
    int           pendingCnt   [3];

    localparam logic [127:0] ALL52   = {16{8'h52}};
    localparam logic [127:0] FIPS_IN = 128'haa5ece06ee6e3c56dde68bac2621bebf;
    localparam logic [127:0] FIPS_EX = 128'h627bceb9999d5aaac945ecf423f56da5;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    inv_sub_shift_stage #(.LANES(1)) dutL1 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .state_in(stateIn[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
        .state_out(stateOut[0]), .busy(busy[0])
    );

    inv_sub_shift_stage #(.LANES(4)) dutL4 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .state_in(stateIn[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
        .state_out(stateOut[1]), .busy(busy[1])
    );

    inv_sub_shift_stage #(.LANES(16)) dutL16 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .state_in(stateIn[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
        .state_out(stateOut[2]), .busy(busy[2])
    );

    // GF(2^8) multiply modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gInv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // InvSbox(x) = inverse of the inverse-affine transform of x.
    function automatic logic [7:0] invSboxModel(input logic [7:0] x);
        return gInv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    // out[r][c] = InvSbox(in[r][(c - r) mod 4]), byte k at row k%4, col k/4.
    function automatic logic [127:0] invSubShiftModel(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8 * (r + 4 * c) -: 8] =
                    invSboxModel(s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction on instance d with out_ready held high:
    // checks acceptance, latency, result and the one-cycle out_valid pulse.
    task automatic applyStimulus(input int d, input logic [127:0] s,
                                 input logic [127:0] exp, input string tag);
        int lat;
        outReady[d] = 1'b1;
        inValid[d]  = 1'b1;
        stateIn[d]  = s;
        checkOutput({tag, "_inReady"}, 128'(inReady[d]), 128'd1);
        @(posedge clk); #1;
        inValid[d] = 1'b0;
        stateIn[d] = ~s;
        checkOutput({tag, "_busy"}, 128'(busy[d]), 128'd1);
        lat = 0;
        while (!outValid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, 128'(lat), 128'(latencyOf[d]));
        checkOutput({tag, "_result"}, stateOut[d], exp);
        @(posedge clk); #1;
        checkOutput({tag, "_pulse"}, 128'(outValid[d]), 128'd0);
    endtask

    // One clock of random-traffic monitoring on all instances: consumes are
    // checked before the edge, accepts are recorded as pending afterwards.
    task automatic stepCycle();
        logic         acc [3];
        logic [127:0] sIn [3];
        for (int d = 0; d < 3; d++) begin
            acc[d] = inValid[d] && inReady[d];
            sIn[d] = stateIn[d];
            if (outValid[d] && outReady[d]) begin
                checkOutput("rand_pending", 128'(pendingCnt[d]), 128'd1);
                checkOutput("rand_result", stateOut[d], invSubShiftModel(pendingState[d]));
                pendingCnt[d] = 0;
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            if (acc[d]) begin
                pendingState[d] = sIn[d];
                pendingCnt[d]   = pendingCnt[d] + 1;
            end
        end
    endtask

    initial begin
        logic [127:0] s;
        logic [127:0] exp;
        int           seen;
        int           lat;

        // Reset with in_valid asserted: nothing may be accepted.
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            inValid[d]    = 1'b1;
            outReady[d]   = 1'b0;
            stateIn[d]    = {$urandom, $urandom, $urandom, $urandom};
            pendingCnt[d] = 0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput("rst_inReady", 128'(inReady[d]), 128'd1);
            checkOutput("rst_outValid", 128'(outValid[d]), 128'd0);
            checkOutput("rst_busy", 128'(busy[d]), 128'd0);
            checkOutput("rst_stateOut", stateOut[d], 128'd0);
        end
        rst = 1'b0;
        for (int d = 0; d < 3; d++) inValid[d] = 1'b0;
        @(posedge clk); #1;

        // Directed vectors on every lane configuration.
        for (int d = 0; d < 3; d++) begin
            applyStimulus(d, 128'd0, ALL52, "zero");
            applyStimulus(d, {16{8'h63}}, 128'd0, "x63");
            applyStimulus(d, FIPS_IN, FIPS_EX, "fips");
        end

        // Backpressure in DONE on the LANES=4 instance.
        s = {$urandom, $urandom, $urandom, $urandom};
        exp = invSubShiftModel(s);
        outReady[1] = 1'b0;
        inValid[1]  = 1'b1;
        stateIn[1]  = s;
        @(posedge clk); #1;
        lat = 0;
        while (!outValid[1] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp_latency", 128'(lat), 128'd4);
        for (int i = 0; i < 10; i++) begin
            inValid[1] = ~inValid[1];
            stateIn[1] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            checkOutput("bp_stable", stateOut[1], exp);
            checkOutput("bp_inReady", 128'(inReady[1]), 128'd0);
            checkOutput("bp_outValid", 128'(outValid[1]), 128'd1);
        end
        inValid[1]  = 1'b0;
        outReady[1] = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_outValid", 128'(outValid[1]), 128'd0);
        checkOutput("bp_release_inReady", 128'(inReady[1]), 128'd1);

        // Reset on the second BUSY edge discards the state in flight.
        inValid[1] = 1'b1;
        stateIn[1] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        inValid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rstbusy_busy", 128'(busy[1]), 128'd0);
        checkOutput("rstbusy_inReady", 128'(inReady[1]), 128'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (outValid[1]) seen = 1;
            @(posedge clk); #1;
        end
        checkOutput("rstbusy_noOutput", 128'(seen), 128'd0);
        applyStimulus(1, 128'd0, ALL52, "post_rst");

        // Random traffic, mostly back-to-back, with random backpressure.
        for (int i = 0; i < 400; i++) begin
            stepCycle();
            for (int d = 0; d < 3; d++) begin
                inValid[d]  = ($urandom % 4) != 0;
                outReady[d] = ($urandom % 4) != 0;
                stateIn[d]  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        for (int d = 0; d < 3; d++) begin
            inValid[d]  = 1'b0;
            outReady[d] = 1'b1;
        end
        for (int i = 0; i < 40; i++) stepCycle();
        for (int d = 0; d < 3; d++) begin
            checkOutput("drain_pending", 128'(pendingCnt[d]), 128'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
